// File: rtl/gpio_switch_debounce.sv
// Switch/button synchroniser and debouncer feeding the MCU GPIO input port.
module gpio_switch_debounce #(
  parameter int NUM_SW       = 16,
  parameter int TICK_DIV     = 1667,
  parameter int STABLE_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [NUM_SW-1:0] sw_db_o,
  output logic [NUM_SW-1:0] sw_rise_o,
  output logic [NUM_SW-1:0] sw_fall_o,
  output logic              sw_chg_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SCNT_LAST = CW'(STABLE_TICKS - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("gpio_switch_debounce: TICK_DIV must be >= 2");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable_ticks
    $error("gpio_switch_debounce: STABLE_TICKS must be >= 1");
  end

  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;
  logic [TW-1:0]     tcnt;
  logic              tick;
  logic [CW-1:0]     scnt     [NUM_SW];
  logic [CW-1:0]     scnt_nxt [NUM_SW];
  logic [NUM_SW-1:0] db_nxt;
  logic [NUM_SW-1:0] rise_nxt;
  logic [NUM_SW-1:0] fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw_i;
      sync2 <= sync1;
    end
  end

  always_comb begin
    tick = (tcnt == TICK_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Any agreement cycle clears the count; the new level is taken on the
  // STABLE_TICKS-th tick of an unbroken disagreement.
  always_comb begin
    scnt_nxt = scnt;
    db_nxt   = sw_db_o;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (sync2[i] == sw_db_o[i]) begin
        scnt_nxt[i] = '0;
      end else if (tick && (scnt[i] == SCNT_LAST)) begin
        db_nxt[i]   = sync2[i];
        scnt_nxt[i] = '0;
        rise_nxt[i] = sync2[i];
        fall_nxt[i] = ~sync2[i];
      end else if (tick) begin
        scnt_nxt[i] = scnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt      <= '{default: '0};
      sw_db_o   <= '0;
      sw_rise_o <= '0;
      sw_fall_o <= '0;
      sw_chg_o  <= 1'b0;
    end else begin
      scnt      <= scnt_nxt;
      sw_db_o   <= db_nxt;
      sw_rise_o <= rise_nxt;
      sw_fall_o <= fall_nxt;
      sw_chg_o  <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Self-checking bench for gpio_switch_debounce with a scoreboard of edge events.
module tb_gpio_switch_debounce;

  localparam int N  = 16;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw = '0;
  logic [N-1:0] sw_db_o, sw_rise_o, sw_fall_o;
  logic         sw_chg_o;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    int           stamp;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  logic [N-1:0] s1_m = '0, s2_m = '0, db_m = '0, act_m = '0;
  int           start_m [N];
  int           n_m = 0;

  gpio_switch_debounce #(
    .NUM_SW      (N),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw_i (raw),
    .sw_db_o  (sw_db_o),
    .sw_rise_o(sw_rise_o),
    .sw_fall_o(sw_fall_o),
    .sw_chg_o (sw_chg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, v, lo, hi, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Negedges elapsed until sw_db_o[idx] shows val (capped at 40).
  task automatic measure(input int idx, input logic val, output int cnt);
    cnt = 0;
    while (sw_db_o[idx] !== val && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Reference model: the pin reaches the debouncer two edges later; a channel
  // accepts the new level on the ST-th tick (every TD-th cycle since reset)
  // counted within an unbroken run of disagreement.
  initial begin : model
    logic [N-1:0] rise_v, fall_v;
    int ticks;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        s1_m = '0; s2_m = '0; db_m = '0; act_m = '0; n_m = 0;
        exp_q.delete();
      end else begin
        rise_v = '0;
        fall_v = '0;
        for (int i = 0; i < N; i++) begin
          if (s2_m[i] == db_m[i]) begin
            act_m[i] = 1'b0;
          end else begin
            if (!act_m[i]) begin
              act_m[i]   = 1'b1;
              start_m[i] = n_m;
            end
            ticks = (n_m + 1) / TD - start_m[i] / TD;
            if (ticks >= ST) begin
              if (s2_m[i]) rise_v[i] = 1'b1;
              else         fall_v[i] = 1'b1;
              act_m[i] = 1'b0;
            end
          end
        end
        db_m = db_m ^ (rise_v | fall_v);
        s2_m = s1_m;
        s1_m = raw;
        n_m++;
        if ((rise_v | fall_v) != '0) exp_q.push_back('{rise_v, fall_v, n_m});
      end
    end
  end

  // Monitor: pops an expected event whenever the DUT shows any pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", 64'({sw_db_o, sw_rise_o, sw_fall_o, sw_chg_o}), 64'd0);
      end else begin
        chk("db_level", 64'(sw_db_o), 64'(db_m));
        if (sw_chg_o || sw_rise_o != '0 || sw_fall_o != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_pulse: rise=%h fall=%h chg=%b, none expected (t=%0t)",
                     sw_rise_o, sw_fall_o, sw_chg_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_rise", 64'(sw_rise_o), 64'(e.rise));
            chk("pulse_fall", 64'(sw_fall_o), 64'(e.fall));
            chk("pulse_chg", 64'(sw_chg_o), 64'd1);
            chk("pulse_cycle", 64'(n_m), 64'(e.stamp));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    // 1. reset with pins high, release with pins low
    raw = '1;
    cyc(5);
    #2;
    raw   = '0;
    rst_n = 1'b1;
    cyc(200);
    chk("t1_db_zero", 64'(sw_db_o), 64'd0);

    // 2. clean step on bit 0
    raw[0] = 1'b1;
    measure(0, 1'b1, c);
    chk_range("t2_latency", c, 11, 14);
    chk("t2_rise", 64'(sw_rise_o), 64'h0001);
    chk("t2_fall", 64'(sw_fall_o), 64'h0000);
    chk("t2_chg", 64'(sw_chg_o), 64'd1);
    cyc(1);
    chk("t2_rise_width", 64'(sw_rise_o), 64'h0000);
    chk("t2_chg_width", 64'(sw_chg_o), 64'd0);

    // 3. bounce on bit 3, then settle high
    for (int k = 0; k < 16; k++) begin
      raw[3] = ~raw[3];
      cyc(5);
    end
    chk("t3_db_bounce", 64'(sw_db_o[3]), 64'd0);
    raw[3] = 1'b1;
    measure(3, 1'b1, c);
    chk_range("t3_latency", c, 11, 14);

    // 4. one-cycle glitch restarts the window on bit 5
    raw[5] = 1'b1;
    cyc(9);
    raw[5] = 1'b0;
    cyc(1);
    raw[5] = 1'b1;
    measure(5, 1'b1, c);
    chk_range("t4_restart_latency", c, 11, 14);

    // 5. simultaneous rise on bit 0 and fall on bit 15
    raw[0]  = 1'b0;
    raw[15] = 1'b1;
    cyc(20);
    chk("t5_pre_db", 64'({sw_db_o[15], sw_db_o[0]}), 64'b10);
    raw[0]  = 1'b1;
    raw[15] = 1'b0;
    c = 0;
    while (!sw_chg_o && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk_range("t5_latency", c, 11, 14);
    chk("t5_rise", 64'(sw_rise_o), 64'h0001);
    chk("t5_fall", 64'(sw_fall_o), 64'h8000);
    cyc(1);
    chk("t5_chg_width", 64'(sw_chg_o), 64'd0);

    // 6. reset pulse mid-count on bit 2
    raw[2] = 1'b1;
    cyc(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_now", 64'({sw_db_o, sw_rise_o, sw_fall_o, sw_chg_o}), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    measure(2, 1'b1, c);
    chk_range("t6_full_window", c, 11, 14);

    // 7. random switching against the model
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 29) == 0) raw[i] = ~raw[i];
    end
    cyc(40);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
